sram_march_bist: RTL and testbench

Parametrised March C- built-in self-test engine for the single-port SRAM macros on our test chips. It drives a generic single-port SRAM port (enable, write, read, address, data in, data out) directly from registers. It checks every read against the expected background and reports the result as pass/fail, the first failing address and element, and a saturating error count. It sits between the pin-level control logic (start, abort, background select) and the macro's BIST port, replacing manual pin-driven read/write testing.

---
 rtl/sram_march_bist_if.sv | 16 +
 rtl/sram_march_bist.sv | 208 ++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_march_bist_if.sv
// Single-port SRAM BIST bus: the engine drives the macro controls,
// and the macro returns read data one cycle after a read.
interface sram_march_bist_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              men;
    logic              wen;
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    modport master (output men, output wen, output ren, output addr, output din, input dout);
    modport slave  (input men, input wen, input ren, input addr, input din, output dout);
endinterface

// File: rtl/sram_march_bist.sv
// March C- BIST engine for a single-port SRAM: six elements over DEPTH words,
// every read checked against the background with first-fail capture.
module sram_march_bist #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] bg,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ERR_W-1:0]  err_cnt,
    sram_march_bist_if.master mem
);
    // Element states encode their March element number in the low 3 bits.
    typedef enum logic [3:0] {
        S_M0 = 4'd0, S_M1 = 4'd1, S_M2 = 4'd2, S_M3 = 4'd3, S_M4 = 4'd4,
        S_M5 = 4'd5, S_DRAIN = 4'd6, S_IDLE = 4'd7, S_DONE = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                phase_reg, phase_next;
    logic [DATA_W-1:0]   bg_reg, bg_next;
    logic                start_ok, abort_ok;

    logic                busy_reg, busy_next, done_reg, done_next;
    logic                mem_men_reg, mem_wen_reg, mem_ren_reg;
    logic                men_next, wen_next, ren_next;
    logic [ADDR_W-1:0]   mem_addr_reg, addr_out_next;
    logic [DATA_W-1:0]   mem_din_reg, din_next;
    logic [DATA_W-1:0]   mem_exp_reg, exp_next;
    logic                inv_wr, inv_rd, rw_elem, wr_op, rd_op;

    logic                cmp_valid_reg;
    logic [DATA_W-1:0]   cmp_exp_reg;
    logic [ADDR_W-1:0]   cmp_addr_reg;
    logic [2:0]          cmp_elem_reg;
    logic                fail_reg;
    logic [2:0]          fail_elem_reg;
    logic [ADDR_W-1:0]   fail_addr_reg;
    logic [DATA_W-1:0]   fail_data_reg;
    logic [ERR_W-1:0]    err_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            phase_reg     <= 1'b0;
            bg_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mem_men_reg   <= 1'b0;
            mem_wen_reg   <= 1'b0;
            mem_ren_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
            mem_exp_reg   <= '0;
            cmp_valid_reg <= 1'b0;
            cmp_exp_reg   <= '0;
            cmp_addr_reg  <= '0;
            cmp_elem_reg  <= '0;
            fail_reg      <= 1'b0;
            fail_elem_reg <= '0;
            fail_addr_reg <= '0;
            fail_data_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            phase_reg     <= phase_next;
            bg_reg        <= bg_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            mem_men_reg   <= men_next;
            mem_wen_reg   <= wen_next;
            mem_ren_reg   <= ren_next;
            mem_addr_reg  <= addr_out_next;
            mem_din_reg   <= din_next;
            mem_exp_reg   <= exp_next;
            // Read data arrives one cycle later; an aborted read is never checked.
            cmp_valid_reg <= mem_ren_reg && !abort_ok;
            cmp_exp_reg   <= mem_exp_reg;
            cmp_addr_reg  <= mem_addr_reg;
            cmp_elem_reg  <= state_reg[2:0];
            if (start_ok) begin
                fail_reg      <= 1'b0;
                fail_elem_reg <= '0;
                fail_addr_reg <= '0;
                fail_data_reg <= '0;
                err_cnt_reg   <= '0;
            end else if (cmp_valid_reg && !abort_ok && (mem.dout != cmp_exp_reg)) begin
                if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + ERR_W'(1);
                if (!fail_reg) begin
                    fail_reg      <= 1'b1;
                    fail_elem_reg <= cmp_elem_reg;
                    fail_addr_reg <= cmp_addr_reg;
                    fail_data_reg <= mem.dout ^ cmp_exp_reg;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        phase_next = phase_reg;
        start_ok   = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
        abort_ok   = abort && busy_reg;
        case (state_reg)
            S_IDLE, S_DONE: if (start_ok) begin
                state_next = S_M0;
                addr_next  = '0;
                phase_next = 1'b0;
            end
            S_M0: if (addr_reg == LAST) begin
                state_next = S_M1;
                addr_next  = '0;
            end else addr_next = addr_reg + ONE;
            S_M1, S_M2: if (!phase_reg) phase_next = 1'b1;
            else begin
                phase_next = 1'b0;
                if (addr_reg != LAST) addr_next = addr_reg + ONE;
                else if (state_reg == S_M1) begin
                    state_next = S_M2;
                    addr_next  = '0;
                end else begin
                    state_next = S_M3;
                    addr_next  = LAST;
                end
            end
            S_M3, S_M4: if (!phase_reg) phase_next = 1'b1;
            else begin
                phase_next = 1'b0;
                if (addr_reg != '0) addr_next = addr_reg - ONE;
                else if (state_reg == S_M3) begin
                    state_next = S_M4;
                    addr_next  = LAST;
                end else begin
                    state_next = S_M5;
                    addr_next  = '0;
                end
            end
            S_M5: if (addr_reg == LAST) state_next = S_DRAIN;
            else addr_next = addr_reg + ONE;
            S_DRAIN: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (abort_ok) begin
            state_next = S_IDLE;
            phase_next = 1'b0;
        end
    end

    // Bus outputs are registered from the next operation so they leave flops cleanly.
    always_comb begin
        bg_next       = start_ok ? bg : bg_reg;
        men_next      = 1'b0;
        wen_next      = 1'b0;
        ren_next      = 1'b0;
        addr_out_next = mem_addr_reg;
        din_next      = mem_din_reg;
        inv_wr        = (state_next == S_M1) || (state_next == S_M3);
        inv_rd        = (state_next == S_M2) || (state_next == S_M4);
        rw_elem       = (state_next == S_M1) || (state_next == S_M2) ||
                        (state_next == S_M3) || (state_next == S_M4);
        wr_op         = (state_next == S_M0) || (rw_elem && phase_next);
        rd_op         = (state_next == S_M5) || (rw_elem && !phase_next);
        exp_next      = inv_rd ? ~bg_next : bg_next;
        if (wr_op) begin
            men_next      = 1'b1;
            wen_next      = 1'b1;
            addr_out_next = addr_next;
            din_next      = inv_wr ? ~bg_next : bg_next;
        end
        if (rd_op) begin
            men_next      = 1'b1;
            ren_next      = 1'b1;
            addr_out_next = addr_next;
        end
        busy_next = (state_next <= S_DRAIN);
        done_next = (state_next == S_DONE);
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign fail      = fail_reg;
    assign fail_elem = fail_elem_reg;
    assign fail_addr = fail_addr_reg;
    assign fail_data = fail_data_reg;
    assign err_cnt   = err_cnt_reg;
    assign mem.men   = mem_men_reg;
    assign mem.wen   = mem_wen_reg;
    assign mem.ren   = mem_ren_reg;
    assign mem.addr  = mem_addr_reg;
    assign mem.din   = mem_din_reg;
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: SRAM model with fault modes, expected bus-op
// queue per run, and a table of full runs plus abort/reset/start-while-busy sequences.
module tb_sram_march_bist;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int EW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] bg = '0;
    logic          busy, done, fail;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [EW-1:0] err_cnt;

    sram_march_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .ERR_W(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .bg        (bg),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_elem (fail_elem),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .err_cnt   (err_cnt),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    // 0 ideal, 1 bit 3 of address 5 stuck at 1, 2 dout stuck 0xFF, 3 dout stuck 0x00
    int            mode = 0;
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem_arr[a];
        if (mode == 1 && a == AW'(5)) v[3] = 1'b1;
        if (mode == 2) v = '1;
        if (mode == 3) v = '0;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_if.men && mem_if.wen) mem_arr[mem_if.addr] <= mem_if.din;
        if (mem_if.men && mem_if.ren) mem_if.dout <= model_read(mem_if.addr);
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    typedef struct {
        int            mode;
        logic [DW-1:0] bg;
        logic          fail;
        logic [2:0]    elem;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [EW-1:0] err;
    } vec_t;

    op_t  exp_q [$];
    vec_t vecs [5];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_op(input logic wr, input int a, input logic [DW-1:0] d);
        exp_q.push_back('{wr, AW'(a), d});
    endtask

    task automatic push_march(input logic [DW-1:0] b);
        for (int a = 0; a < DEP; a++) push_op(1'b1, a, b);
        for (int a = 0; a < DEP; a++) begin push_op(1'b0, a, '0); push_op(1'b1, a, ~b); end
        for (int a = 0; a < DEP; a++) begin push_op(1'b0, a, '0); push_op(1'b1, a, b); end
        for (int a = DEP - 1; a >= 0; a--) begin push_op(1'b0, a, '0); push_op(1'b1, a, ~b); end
        for (int a = DEP - 1; a >= 0; a--) begin push_op(1'b0, a, '0); push_op(1'b1, a, b); end
        for (int a = 0; a < DEP; a++) push_op(1'b0, a, '0);
    endtask

    task automatic check_bus();
        op_t e;
        if (mem_if.men) begin
            if (exp_q.size() == 0) check("bus_op_unexpected", 32'(mem_if.men), 0);
            else begin
                e = exp_q.pop_front();
                check("bus_op",
                      32'({mem_if.wen, mem_if.ren, mem_if.addr, mem_if.wen ? mem_if.din : 8'h00}),
                      32'({e.wr, ~e.wr, e.addr, e.wr ? e.din : 8'h00}));
            end
        end
    endtask

    task automatic begin_run(input int m, input logic [DW-1:0] b);
        @(negedge clk);
        mode  = m;
        bg    = b;
        start = 1'b1;
        exp_q.delete();
        push_march(b);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
    endtask

    // Walk busy cycles up to until_c, checking each bus op; optionally poke start mid-run.
    task automatic advance(input int until_c, input bit spurious);
        while (busy && cyc < until_c) begin
            cyc++;
            check_bus();
            start = spurious && (cyc == 40 || cyc == 100);
            if (start) bg = 8'h77;
            if (cyc < until_c) @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_done(input string tag, input vec_t v);
        $display("run %s: mode=%0d bg=%02h cycles=%0d fail=%0d elem=%0d addr=%0d data=%02h err=%0d",
                 tag, v.mode, v.bg, cyc, fail, fail_elem, fail_addr, fail_data, err_cnt);
        check({tag, "_cycles"}, 32'(cyc), 161);
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        check({tag, "_done_busy_men"}, 32'({done, busy, mem_if.men}), 32'(3'b100));
        check({tag, "_fail"}, 32'(fail), 32'(v.fail));
        check({tag, "_fail_elem"}, 32'(fail_elem), 32'(v.elem));
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'(v.addr));
        check({tag, "_fail_data"}, 32'(fail_data), 32'(v.data));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(v.err));
    endtask

    initial begin
        vec_t clean0;
        vecs[0] = '{0, 8'h00, 1'b0, 3'd0, 5'd0, 8'h00, 8'd0};
        vecs[1] = '{1, 8'h00, 1'b1, 3'd1, 5'd5, 8'h08, 8'd3};
        vecs[2] = '{0, 8'hA5, 1'b0, 3'd0, 5'd0, 8'h00, 8'd0};
        vecs[3] = '{2, 8'h00, 1'b1, 3'd1, 5'd0, 8'hFF, 8'd48};
        vecs[4] = '{0, 8'h3C, 1'b0, 3'd0, 5'd0, 8'h00, 8'd0};
        clean0  = vecs[0];

        #1;
        check("reset_status", 32'({busy, done, fail, fail_elem, fail_addr, fail_data, err_cnt}), 0);
        check("reset_bus", 32'({mem_if.men, mem_if.wen, mem_if.ren, mem_if.addr, mem_if.din}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            begin_run(vecs[i].mode, vecs[i].bg);
            advance(2000, 1'b0);
            check_done($sformatf("vec%0d", i), vecs[i]);
        end

        // Abort on the M2 write of address 7 with dout stuck low: seven M2 reads already
        // failed, the pending compare of address 7 must be dropped.
        begin_run(3, 8'h00);
        advance(64, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("abort: busy=%0d men=%0d done=%0d fail=%0d elem=%0d err=%0d",
                 busy, mem_if.men, done, fail, fail_elem, err_cnt);
        check("abort_busy_men_done", 32'({busy, mem_if.men, done}), 0);
        check("abort_fail", 32'(fail), 1);
        check("abort_fail_elem", 32'(fail_elem), 2);
        check("abort_err_cnt", 32'(err_cnt), 7);
        @(negedge clk);
        check("abort_stays_idle", 32'({busy, done, mem_if.men}), 0);
        begin_run(0, 8'h00);
        advance(2000, 1'b0);
        check_done("restart", clean0);

        // Asynchronous reset between clock edges in M4 with errors logged.
        begin_run(2, 8'h5A);
        advance(120, 1'b0);
        check("pre_reset_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        $display("reset mid-run: busy=%0d fail=%0d err=%0d men=%0d din=%02h",
                 busy, fail, err_cnt, mem_if.men, mem_if.din);
        check("midrun_reset_status",
              32'({busy, done, fail, fail_elem, fail_addr, fail_data, err_cnt}), 0);
        check("midrun_reset_bus",
              32'({mem_if.men, mem_if.wen, mem_if.ren, mem_if.addr, mem_if.din}), 0);
        @(negedge clk);
        rst = 1'b0;

        // start (with a different bg) pulsed while busy must not disturb the run.
        begin_run(0, 8'h3C);
        advance(2000, 1'b1);
        check_done("start_while_busy", vecs[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
